// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types for the VGA control/status register space.
// Holds the default-width address/data types, the response code enum and
// the address+data bus payload used by the register file.
package vga_axil_pkg;

    parameter int unsigned AXIL_ADDR_W = 8;
    parameter int unsigned AXIL_DATA_W = 32;

    typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
    typedef logic [AXIL_DATA_W-1:0] axil_data_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axil_resp_e;

    typedef struct packed {
        axil_addr_t addr;
        axil_data_t data;
    } axil_addr_data_t;

endpackage

// File: rtl/vga_axil_regfile_wr_ctrl.sv
// Write-side control for the AXI4-Lite register file.
// Latches AW and W independently, decides the write response, issues a
// single-cycle commit (index, byte mask, masked data) to the register
// array and runs the B channel.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   awaddr/awvalid/awready   AW channel
//   wdata/wstrb/wvalid/wready W channel
//   bresp/bvalid/bready      B channel
//   commit_c                 write the register array this cycle
//   index_c                  register index being written
//   mask_c                   bit mask expanded from the byte strobes
//   data_c                   write data already ANDed with mask_c
import vga_axil_pkg::*;

module vga_axil_regfile_wr_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned OFF_W  = $clog2(STRB_W),
    localparam int unsigned IDX_W  = ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit_c,
    output logic [IDX_W-1:0]  index_c,
    output logic [DATA_W-1:0] mask_c,
    output logic [DATA_W-1:0] data_c
);

    // Read-only mask widened to cover every decodable index.
    localparam int unsigned IDX_N = 1 << IDX_W;
    localparam logic [IDX_N-1:0] RO_EXT = IDX_N'(RO_MASK);

    typedef enum logic {W_IDLE, W_RESP} w_state_e;

    w_state_e          state;
    logic              aw_held;
    logic              w_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    axil_resp_e        bresp_q;
    logic              bvalid_q;

    logic              aw_hs;
    logic              w_hs;
    logic              fire;
    logic [IDX_W-1:0]  cur_idx;
    logic [DATA_W-1:0] cur_data;
    logic [STRB_W-1:0] cur_strb;
    logic [DATA_W-1:0] mask;
    axil_resp_e        resp;

    // Byte-offset address bits carry no information for word registers.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^awaddr[OFF_W-1:0];

    // Ready depends only on registered state and reset, never on bready.
    assign awready = (state == W_IDLE) && !aw_held && !rst;
    assign wready  = (state == W_IDLE) && !w_held && !rst;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // A held beat wins over the live bus; otherwise the live beat is used.
    assign cur_idx  = aw_held ? aw_idx_q : awaddr[ADDR_W-1:OFF_W];
    assign cur_data = w_held ? wdata_q : wdata;
    assign cur_strb = w_held ? wstrb_q : wstrb;

    assign fire = (state == W_IDLE) && !rst
                  && (aw_held || aw_hs) && (w_held || w_hs);

    // Response decode: out-of-range index first, then read-only check.
    always_comb begin
        resp = OKAY;
        if (32'(cur_idx) >= NUM_REGS) begin
            resp = DECERR;
        end else if (RO_EXT[cur_idx]) begin
            resp = SLVERR;
        end
    end

    // Expand byte strobes to a bit mask.
    always_comb begin
        mask = '0;
        for (int b = 0; b < int'(STRB_W); b++) begin
            mask[b*8 +: 8] = {8{cur_strb[b]}};
        end
    end

    // Error responses never touch the register array.
    assign commit_c = fire && (resp == OKAY);
    assign index_c  = cur_idx;
    assign mask_c   = mask;
    assign data_c   = cur_data & mask;

    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;

    // Write FSM with AW/W latching and registered B channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
            bvalid_q <= 1'b0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (fire) begin
                        state    <= W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= resp;
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            aw_idx_q <= awaddr[ADDR_W-1:OFF_W];
                        end
                        if (w_hs) begin
                            w_held  <= 1'b1;
                            wdata_q <= wdata;
                            wstrb_q <= wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        state    <= W_IDLE;
                        bvalid_q <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite register file for the VGA controller control/status space.
// NUM_REGS word registers with byte strobes; registers flagged in RO_MASK
// are read-only and return the matching hw_i slice. Write handling lives
// in vga_axil_regfile_wr_ctrl; this level holds the array and read FSM.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   aw*/w*/b*                    AXI4-Lite write channels
//   ar*/r*                       AXI4-Lite read channels
//   hw_i                         status values for read-only registers
//   regs_o                       register contents (read-only slices are 0)
import vga_axil_pkg::*;

module vga_axil_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_i,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;

    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    logic              commit_c;
    logic [IDX_W-1:0]  index_c;
    logic [DATA_W-1:0] mask_c;
    logic [DATA_W-1:0] data_c;

    r_state_e          r_state;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    axil_resp_e        rresp_q;

    logic              ar_hs;
    logic [IDX_W-1:0]  ar_idx;
    logic [DATA_W-1:0] rd_val;
    axil_resp_e        rd_resp;

    // Byte-offset read address bits and status slices of writable
    // registers are intentionally ignored.
    logic unused_rd;
    assign unused_rd = ^{araddr[OFF_W-1:0], hw_i};

    vga_axil_regfile_wr_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_wr_ctrl (
        .clk      (clk),
        .rst      (rst),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .commit_c (commit_c),
        .index_c  (index_c),
        .mask_c   (mask_c),
        .data_c   (data_c)
    );

    // Register array: writable registers update on commit, read-only
    // slots are constant zero.
    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_reg
        if (RO_MASK[k]) begin : g_ro
            assign regs_o[k*DATA_W +: DATA_W] = '0;
        end else begin : g_rw
            logic [DATA_W-1:0] q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= RESET_VAL;
                end else if (commit_c && (index_c == IDX_W'(k))) begin
                    q <= (q & ~mask_c) | data_c;
                end
            end
            assign regs_o[k*DATA_W +: DATA_W] = q;
        end
    end

    assign arready = (r_state == R_IDLE) && !rst;
    assign ar_hs   = arvalid && arready;
    assign ar_idx  = araddr[ADDR_W-1:OFF_W];

    // Read mux; regs_o is the pre-commit value so a same-edge write is
    // not visible to the read.
    always_comb begin
        rd_resp = OKAY;
        rd_val  = '0;
        if (32'(ar_idx) >= NUM_REGS) begin
            rd_resp = DECERR;
        end else begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                if (ar_idx == IDX_W'(k)) begin
                    rd_val = RO_MASK[k] ? hw_i[k*DATA_W +: DATA_W]
                                        : regs_o[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

    // Read FSM: capture on AR handshake, hold until R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state  <= R_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_val;
                        rresp_q  <= rd_resp;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state  <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vga_axil_regfile.md
# vga_axil_regfile

Parametrised AXI4-Lite slave register file for the VGA controller's control/status space. It replaces the fixed-width single-register loopback target with a configurable bank of NUM_REGS registers. It adds byte strobes, per-register read-only masking, decoupled AW/W acceptance, backpressure on B/R and error responses. Register contents drive the timing and format logic; read-only registers expose hardware status.

## Interface
Parameters:
- DATA_W, 32, data width in bits; must be 32 or 64.
- ADDR_W, 8, byte-address width.
- NUM_REGS, 16, number of registers; NUM_REGS*DATA_W/8 must not exceed 2**ADDR_W.
- RO_MASK, '0, NUM_REGS-bit mask; a set bit makes that register read-only.
- RESET_VAL, '0, reset value applied to every writable register.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- awaddr  in  ADDR_W  write address.
- awvalid / awready  in / out  1  AW handshake.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte strobes.
- wvalid / wready  in / out  1  W handshake.
- bresp  out  2  write response.
- bvalid / bready  out / in  1  B handshake.
- araddr  in  ADDR_W  read address.
- arvalid / arready  in / out  1  AR handshake.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response.
- rvalid / rready  out / in  1  R handshake.
- hw_i  in  NUM_REGS*DATA_W  status values; slice k is returned for read-only register k.
- regs_o  out  NUM_REGS*DATA_W  current register contents; slice k is register k; read-only slices are 0.

## Operation
- Decode: index = addr[ADDR_W-1:log2(DATA_W/8)]; low byte-offset bits are ignored.
- Response codes: OKAY = 0; SLVERR = 2 for a write to a read-only register; DECERR = 3 when index >= NUM_REGS.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready = !aw_held; wready = !w_held. AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - On the edge where both AW and W are available (held or handshaking that cycle), the write commits and the FSM moves to W_RESP.
  - A commit updates only the bytes with wstrb set; wstrb = 0 commits nothing but still responds OKAY.
  - DECERR and SLVERR writes update no state.
  - W_RESP: bvalid = 1 and awready = wready = 0. On bvalid && bready, held flags clear and the FSM returns to W_IDLE.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready = 1. On the AR handshake, rdata and rresp are registered and the FSM moves to R_RESP.
  - R_RESP: rvalid = 1 and arready = 0; rdata and rresp are stable until rvalid && rready, then the FSM returns to R_IDLE.
  - A DECERR read returns rdata = 0.
  - A read-only register returns the hw_i slice sampled at the AR handshake edge.
- Read and write FSMs are fully independent. One outstanding transaction per channel.
- A read and a write commit to the same register on the same edge: the read returns the pre-write value.

## Timing
- Reset (rst = 1 at an edge):
  - writable registers = RESET_VAL;
  - bvalid = rvalid = 0;
  - bresp = rresp = OKAY;
  - rdata = 0;
  - held AW/W are discarded; both FSMs go to IDLE.
  - awready, wready and arready are forced to 0 while rst = 1.
- Reset mid-transaction: the pending transaction is dropped with no B/R response, and partially latched AW/W are lost.
- Write latency: AW and W both handshaking at edge N → regs_o updated and bvalid = 1 from edge N. Next awready is 1 in the cycle after the B handshake edge.
- Read latency: AR handshake at edge N → rvalid = 1 from edge N. Back-to-back read throughput is one read every 2 cycles with rready held at 1.
- The slave never combinationally waits on bready or rready to assert awready, wready or arready.

## Structure
- vga_axil_pkg holds:
  - axil_addr_t and axil_data_t, parametrised via package parameters matching the default widths;
  - axil_resp_e (OKAY, EXOKAY, SLVERR, DECERR);
  - axil_addr_data_t.
- Sub-module vga_axil_regfile_wr_ctrl contains the AW/W latching, the write FSM and commit generation.
  - Its outputs are commit, index and strb-masked data, plus the B channel.
  - The top level holds the register array, decode and read FSM.

## Test plan
All scenarios use default parameters and RO_MASK = 16'h8000.
- Write 0x0C, data 0xDEADBEEF, wstrb 0xF, AW/W in the same cycle → bresp OKAY; read 0x0C → rdata 0xDEADBEEF, rresp OKAY.
- W issued 3 cycles before AW to 0x04, data 0x11223344, wstrb 0x5 over reset value 0 → read returns 0x00220044.
- Write 0x40 (index 16) → bresp DECERR, no register changes; read 0x40 → rresp DECERR, rdata 0.
- hw_i slice 15 = 0xCAFE0001; write 0x3C → bresp SLVERR; read 0x3C → rdata 0xCAFE0001, rresp OKAY.
- Hold bready = 0 for 5 cycles after a write → bvalid stays 1, awready and wready stay 0, the response is unchanged; a concurrent read still completes.
- Assert rst while in W_RESP after writing 0x55 to 0x08 → bvalid = 0 next cycle; read 0x08 → 0.
